sr_latch_driver: RTL
====================

// Module: sr_latch_driver
// PURPOSE
//  - Clocked initiator for the NAND SR latch interface: drives active-low set/reset (s, r), reads back q1/q2.
//  - Accepts set/reset/toggle/read commands over a valid/ready handshake.
//  - Generates a timed s/r pulse, waits for the latch to settle, samples q1/q2 through a 2-flop synchroniser.
//  - Returns the resulting state plus a mismatch/forbidden-state error. Sits between lab control logic and the latch.
// PARAMETERS
//  - PULSE_CYCLES   default 2   cycles s or r is held low per command; legal range 1..255
//  - SETTLE_CYCLES  default 3   cycles to wait after releasing s/r before sampling; legal range 1..255, covers sync latency
// PORTS
//  clk        in   1  single clock; all logic rising-edge
//  rst        in   1  synchronous, active-high reset
//  cmd_valid  in   1  command present
//  cmd_op     in   2  00 READ, 01 SET (q1->1), 10 RESET (q1->0), 11 TOGGLE
//  cmd_ready  out  1  high only in IDLE
//  s          out  1  active-low set to latch; 1 = inactive
//  r          out  1  active-low reset to latch; 1 = inactive
//  q1         in   1  latch output (asynchronous)
//  q2         in   1  latch complementary output (asynchronous)
//  rsp_valid  out  1  one-cycle pulse: result available
//  rsp_q      out  1  sampled q1 at check time
//  rsp_err    out  1  with rsp_valid: q1 != expected, or q1 == q2
//  busy       out  1  FSM not in IDLE
// BEHAVIOUR
//  - Reset values: s=1, r=1, cmd_ready=0 during rst then 1, rsp_valid=0, rsp_q=0, rsp_err=0, busy=0; FSM -> IDLE; counters and sync flops cleared.
//  - q1/q2 are each passed through a 2-flop synchroniser (q1_s, q2_s); all decisions use the synchronised values.
//  - Handshake: command accepted on the cycle where cmd_valid && cmd_ready. op is registered. cmd_ready=0 until back in IDLE.
//  - FSM states and transitions:
//    - IDLE: on accept, READ -> SETTLE; SET/RESET -> PULSE.
//      TOGGLE resolves to SET if q1_s==0, else RESET, using q1_s at the accept cycle; then -> PULSE.
//      Expected value: 1 for SET, 0 for RESET; READ has no expectation.
//    - PULSE: s=0 (SET) or r=0 (RESET) for exactly PULSE_CYCLES cycles. s and r are never both 0 in any state. -> SETTLE.
//    - SETTLE: s=r=1; count SETTLE_CYCLES. -> CHECK.
//    - CHECK: one cycle; rsp_valid=1, rsp_q=q1_s. rsp_err=1 if q1_s==q2_s, or (op!=READ and q1_s!=expected). -> IDLE.
//  - Latency: accept to rsp_valid = PULSE_CYCLES + SETTLE_CYCLES + 1 cycles for SET/RESET/TOGGLE; SETTLE_CYCLES + 1 for READ.
//  - Back-to-back: the next command can be accepted the cycle after CHECK. A cmd_valid held during busy is not consumed.
//  - Reset mid-operation: s/r return to 1 on the next edge, no rsp_valid is issued, and the pending command is dropped.
//  - Counters are 8 bits. A counter reaching its parameter value ends the state; it never wraps within a state.
// CONFIGURATION
//  - Macro SR_DRV_FORBID_MON_EN defined: adds output err_sticky (1 bit, reset 0).
//    err_sticky sets when q1_s==q2_s for 2 consecutive cycles in any state, or when rsp_err is reported.
//    It clears only on rst or on an accepted READ command.
//  - Macro not defined: no err_sticky port or logic; rsp_err is the only error indication.
// STRUCTURE
//  - Package sr_drv_pkg: cmd_op encodings (OP_READ/OP_SET/OP_RESET/OP_TOGGLE), FSM state enum (IDLE/PULSE/SETTLE/CHECK), counter width constant CNT_W=8.
//  - One sub-module, sync2: 2-flop synchroniser, instantiated for q1 and q2. It uses sync rst and clears to 0.
//  - The FSM, counters and response registers live in sr_latch_driver.
// TESTING (bench instantiates the NAND SR latch as the DUT load)
//  1. rst held 3 cycles -> s=1, r=1, rsp_valid=0, busy=0; cmd_ready=1 the cycle after rst drops.
//  2. SET with defaults -> s=0 for exactly 2 cycles, r=1 throughout. rsp_valid 6 cycles after accept: rsp_q=1, rsp_err=0.
//  3. RESET, then TOGGLE twice -> responses rsp_q=0, 1, 0; every TOGGLE drives the correct one of s/r; rsp_err=0.
//  4. Bench forces q1=q2=1 and issues READ -> rsp_valid 4 cycles after accept with rsp_err=1; err_sticky=1 when the macro is defined.
//  5. rst asserted during PULSE of a SET -> next edge s=r=1, no rsp_valid, IDLE; a following READ returns the latch's current state.
//  6. cmd_valid held high for 3 commands -> exactly 3 accepts, one per IDLE, and s/r are never both low.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR latch driver: command opcodes, FSM states, counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sr_drv_pkg;

    // Width of the pulse/settle counters; parameters are limited to 1..255.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_SET    = 2'b01,   // drive q1 -> 1
        OP_RESET  = 2'b10,   // drive q1 -> 0
        OP_TOGGLE = 2'b11    // resolves to SET or RESET from the current q1
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PULSE  = 2'b01,
        SETTLE = 2'b10,
        CHECK  = 2'b11
    } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous input bit; both flops clear to 0 on reset.
// Latency: 2 clk cycles from input change to output.
// Backpressure: none (free-running).
// Ports: clk, rst (sync, active-high), d_i (async input), q_o (synchronised output).
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked initiator for a NAND SR latch: pulses active-low s/r, waits to settle, checks q1/q2.
// Latency: accept -> rsp_valid = PULSE_CYCLES+SETTLE_CYCLES+1 (SET/RESET/TOGGLE), SETTLE_CYCLES+1 (READ).
// Backpressure: cmd_ready only in IDLE; a command held during busy waits, it is not consumed.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_op/cmd_ready command handshake;
//        s, r active-low latch drives; q1, q2 async latch outputs; rsp_valid/rsp_q/rsp_err
//        one-cycle response; busy (not IDLE). Build macro SR_DRV_FORBID_MON_EN adds err_sticky.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       s,
    output logic       r,
    input  logic       q1,
    input  logic       q2,
    output logic       rsp_valid,
    output logic       rsp_q,
    output logic       rsp_err,
    output logic       busy
`ifdef SR_DRV_FORBID_MON_EN
    ,
    output logic       err_sticky
`endif
);

    // Terminal counts: a state ends on the cycle its counter hits LAST.
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic q1_s;
    logic q2_s;

    sync2 u_sync_q1 (
        .clk (clk),
        .rst (rst),
        .d_i (q1),
        .q_o (q1_s)
    );

    sync2 u_sync_q2 (
        .clk (clk),
        .rst (rst),
        .d_i (q2),
        .q_o (q2_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             is_read_q, is_read_d;
    // Target q1 value; for TOGGLE it is frozen at accept time.
    logic             exp_q,   exp_d;

    logic accept;

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_read_q <= 1'b0;
            exp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_read_q <= is_read_d;
            exp_q     <= exp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_read_d = is_read_q;
        exp_d     = exp_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    case (op_e'(cmd_op))
                        OP_READ: begin
                            is_read_d = 1'b1;
                            exp_d     = 1'b0;
                            state_d   = SETTLE;
                        end
                        OP_SET: begin
                            is_read_d = 1'b0;
                            exp_d     = 1'b1;
                            state_d   = PULSE;
                        end
                        OP_RESET: begin
                            is_read_d = 1'b0;
                            exp_d     = 1'b0;
                            state_d   = PULSE;
                        end
                        default: begin
                            // TOGGLE: drive toward the opposite of what the latch shows now.
                            is_read_d = 1'b0;
                            exp_d     = ~q1_s;
                            state_d   = PULSE;
                        end
                    endcase
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Only one of s/r can be low, and only in PULSE, so the forbidden 0/0 input never occurs.
    assign s = !((state_q == PULSE) && exp_q);
    assign r = !((state_q == PULSE) && !exp_q);

    // Gated by rst so an interrupted CHECK never emits a response.
    assign rsp_valid = (state_q == CHECK) && !rst;
    assign rsp_q     = rsp_valid && q1_s;
    assign rsp_err   = rsp_valid &&
                       ((q1_s == q2_s) || (!is_read_q && (q1_s != exp_q)));
    assign busy      = (state_q != IDLE);

`ifdef SR_DRV_FORBID_MON_EN
    // Forbidden/invalid latch state monitor: q1_s==q2_s on two consecutive cycles,
    // or any reported rsp_err, latches an error until rst or an accepted READ.
    logic eq_prev_q;
    logic sticky_q;
    logic eq_now;

    assign eq_now = (q1_s == q2_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            eq_prev_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            eq_prev_q <= eq_now;
            if ((eq_now && eq_prev_q) || rsp_err) begin
                sticky_q <= 1'b1;
            end else if (accept && (op_e'(cmd_op) == OP_READ)) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign err_sticky = sticky_q;
`endif

endmodule
